// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side pointer and flag controller for an asynchronous FIFO.
// It keeps the binary read pointer, drives the RAM read address, and exports
// the Gray read pointer to the write domain. It also registers the empty,
// almost-empty and occupancy flags, which are computed against the write
// pointer after it has been synchronised into this clock domain.
//
// Ports
//   rclk          in   read clock; all state updates on its rising edge
//   rrst_n        in   asynchronous active-low reset
//   rinc          in   read request for this cycle
//   rq2_wptr      in   synchronised Gray write pointer   [ADDR_SIZE:0]
//   ae_thresh     in   almost-empty threshold in entries [ADDR_SIZE:0]
//   clr_err       in   clears the sticky underflow flag
//   raddr         out  RAM read address (state only)    [ADDR_SIZE-1:0]
//   rptr          out  registered Gray read pointer     [ADDR_SIZE:0]
//   rempty        out  registered empty flag
//   ralmost_empty out  registered almost-empty flag
//   rlevel        out  registered occupancy, 0..2**ADDR_SIZE
//   runderflow    out  sticky read-while-empty error
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rinc,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  input  logic [ADDR_SIZE:0]   ae_thresh,
  input  logic                 clr_err,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   rlevel,
  output logic                 runderflow
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbin_next;
  logic [ADDR_SIZE:0] rgray_next;
  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] level_next;
  logic               rd_ok;
  logic               rd_bad;

  // A read only advances the pointer when the FIFO is not empty; a request
  // against an empty FIFO is recorded as underflow instead.
  assign rd_ok  = rinc & ~rempty;
  assign rd_bad = rinc &  rempty;

  assign rbin_next  = rbin + PW'(rd_ok);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    wbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  // Modular subtraction keeps the occupancy correct across pointer wrap.
  assign level_next = wbin - rbin_next;

  assign raddr = rbin[ADDR_SIZE-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rq2_wptr);
      ralmost_empty <= (level_next <= ae_thresh);
      rlevel        <= level_next;
    end
  end

  // Sticky error: a new underflow takes priority over a simultaneous clear.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rd_bad) begin
      runderflow <= 1'b1;
    end else if (clr_err) begin
      runderflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  localparam int unsigned ADDR_SIZE = 4;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] rq2_wptr;
  logic [4:0] ae_thresh;
  logic       clr_err;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(.ADDR_SIZE(ADDR_SIZE)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .ae_thresh     (ae_thresh),
    .clr_err       (clr_err),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rempty"}, 32'(rempty), 32'd1);
    check({tag, "_ralmost"}, 32'(ralmost_empty), 32'd1);
    check({tag, "_rlevel"}, 32'(rlevel), 32'd0);
    check({tag, "_rptr"}, 32'(rptr), 32'd0);
    check({tag, "_raddr"}, 32'(raddr), 32'd0);
    check({tag, "_runderflow"}, 32'(runderflow), 32'd0);
  endtask

  initial begin
    rrst_n    = 1'b1;
    rinc      = 1'b0;
    rq2_wptr  = 5'b00000;
    ae_thresh = 5'd2;
    clr_err   = 1'b0;

    // Asynchronous reset, observed before the first clock edge.
    #1 rrst_n = 1'b0;
    #1 check_reset_vals("reset");
    step();
    step();
    rrst_n = 1'b1;
    step();
    check("idle_rempty", 32'(rempty), 32'd1);
    check("idle_rlevel", 32'(rlevel), 32'd0);

    // Fill: write pointer at gray(3).
    rq2_wptr = 5'b00010;
    step();
    check("fill_rempty", 32'(rempty), 32'd0);
    check("fill_rlevel", 32'(rlevel), 32'd3);
    check("fill_ralmost", 32'(ralmost_empty), 32'd0);

    // Drain three entries.
    rinc = 1'b1;
    check("drain_raddr0", 32'(raddr), 32'd0);
    step();
    check("drain_raddr1", 32'(raddr), 32'd1);
    check("drain1_rlevel", 32'(rlevel), 32'd2);
    check("drain1_ralmost", 32'(ralmost_empty), 32'd1);
    step();
    check("drain_raddr2", 32'(raddr), 32'd2);
    check("drain2_rlevel", 32'(rlevel), 32'd1);
    step();
    check("drain3_rempty", 32'(rempty), 32'd1);
    check("drain3_rlevel", 32'(rlevel), 32'd0);
    check("drain3_rptr", 32'(rptr), 32'b00010);
    check("drain3_raddr", 32'(raddr), 32'd3);

    // Underflow handling.
    step();
    check("uf_raddr", 32'(raddr), 32'd3);
    check("uf_rptr", 32'(rptr), 32'b00010);
    check("uf_set", 32'(runderflow), 32'd1);
    rinc = 1'b0; clr_err = 1'b1;
    step();
    check("uf_clr", 32'(runderflow), 32'd0);
    rinc = 1'b1; clr_err = 1'b1;
    step();
    check("uf_set_wins", 32'(runderflow), 32'd1);
    rinc = 1'b0; clr_err = 1'b0;
    step();
    check("uf_sticky", 32'(runderflow), 32'd1);
    clr_err = 1'b1;
    step();
    check("uf_clr2", 32'(runderflow), 32'd0);
    clr_err = 1'b0;

    // Full FIFO: write pointer gray(19), read pointer 3.
    rq2_wptr = 5'b11010;
    step();
    check("full_rlevel", 32'(rlevel), 32'd16);
    check("full_ralmost", 32'(ralmost_empty), 32'd0);
    rinc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("rd16_rlevel", 32'(rlevel), 32'(16 - i));
    end
    check("rd16_rempty", 32'(rempty), 32'd1);
    check("rd16_raddr", 32'(raddr), 32'd3);

    // Move both pointers to 31.
    rinc = 1'b0;
    rq2_wptr = 5'b10000;
    step();
    check("to31_rlevel", 32'(rlevel), 32'd12);
    rinc = 1'b1;
    for (int i = 0; i < 12; i++) step();
    rinc = 1'b0;
    check("at31_rempty", 32'(rempty), 32'd1);
    check("at31_rptr", 32'(rptr), 32'b10000);
    check("at31_raddr", 32'(raddr), 32'd15);

    // Write side wraps to gray(2); read across the wrap.
    rq2_wptr = 5'b00011;
    step();
    check("wrap_rlevel", 32'(rlevel), 32'd3);
    check("wrap_rempty", 32'(rempty), 32'd0);
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    check("wrap_rptr", 32'(rptr), 32'b00000);
    check("wrap_raddr", 32'(raddr), 32'd0);
    check("wrap_rlevel2", 32'(rlevel), 32'd2);

    // Threshold changes take effect on the next edge; 0 tracks rempty.
    ae_thresh = 5'd0;
    step();
    check("ae0_ralmost", 32'(ralmost_empty), 32'd0);
    ae_thresh = 5'd2;
    step();
    check("ae2_ralmost", 32'(ralmost_empty), 32'd1);

    // Reset mid-operation: write pointer gray(6), read pointer at 1.
    rq2_wptr = 5'b00101;
    step();
    check("pre_rlevel6", 32'(rlevel), 32'd6);
    rinc = 1'b1;
    step();
    check("pre_rlevel5", 32'(rlevel), 32'd5);
    check("pre_raddr", 32'(raddr), 32'd1);
    #2 rrst_n = 1'b0;
    #1 check_reset_vals("midrst");
    #1 rrst_n = 1'b1;
    step();
    check("post_raddr", 32'(raddr), 32'd0);
    check("post_rlevel", 32'(rlevel), 32'd6);
    check("post_rempty", 32'(rempty), 32'd0);
    check("post_runderflow", 32'(runderflow), 32'd1);
    step();
    check("post_adv_raddr", 32'(raddr), 32'd1);
    check("post_adv_rlevel", 32'(rlevel), 32'd5);
    rinc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4, log2 of FIFO depth (depth = 2**ADDR_SIZE); pointers are ADDR_SIZE+1 bits wide.
REQ-002 SHALL have port rclk, input, 1, read clock; all state updates on its rising edge.
REQ-003 SHALL have port rrst_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rinc, input, 1, read request for this cycle.
REQ-005 SHALL have port rq2_wptr, input, ADDR_SIZE+1, write pointer already synchronized into rclk, Gray-coded.
REQ-006 SHALL have port ae_thresh, input, ADDR_SIZE+1, almost-empty threshold in entries.
REQ-007 SHALL have port clr_err, input, 1, clears the sticky underflow flag.
REQ-008 SHALL have port raddr, output, ADDR_SIZE, RAM read address.
REQ-009 SHALL have port rptr, output, ADDR_SIZE+1, registered Gray read pointer, sent to the write domain.
REQ-010 SHALL have port rempty, output, 1, registered empty flag.
REQ-011 SHALL have port ralmost_empty, output, 1, registered almost-empty flag.
REQ-012 SHALL have port rlevel, output, ADDR_SIZE+1, registered read-side occupancy, 0..2**ADDR_SIZE.
REQ-013 SHALL have port runderflow, output, 1, sticky read-while-empty error.

Function
REQ-014 SHALL hold binary read pointer rbin (ADDR_SIZE+1 bits); rbin_next = rbin + (rinc AND NOT rempty), modulo 2**(ADDR_SIZE+1).
REQ-015 SHALL form rgray_next = (rbin_next >> 1) XOR rbin_next, and register rptr <= rgray_next every edge.
REQ-016 SHALL drive raddr = rbin[ADDR_SIZE-1:0] straight from the register, giving zero added latency to the RAM address.
REQ-017 SHALL register rempty <= (rgray_next == rq2_wptr); the flag clears one edge after rq2_wptr moves and sets on the same edge as the last read.
REQ-018 SHALL convert rq2_wptr to binary wbin combinationally, with bit i = XOR of Gray bits ADDR_SIZE down to i.
REQ-019 SHALL register rlevel <= (wbin - rbin_next) modulo 2**(ADDR_SIZE+1); rlevel updates on the same edge as rempty.
REQ-020 SHALL register ralmost_empty <= ((wbin - rbin_next) <= ae_thresh), as an unsigned compare; ae_thresh=0 makes it equal to rempty.
REQ-021 SHALL treat rinc while rempty=1 as underflow: the pointer does not advance, and runderflow is set on the next edge.
REQ-022 SHALL keep runderflow set until an edge with clr_err=1; when underflow and clr_err occur together, set wins.
REQ-023 SHALL handle pointer wrap from 2**(ADDR_SIZE+1)-1 to 0 seamlessly; level and flags stay correct across the wrap.
REQ-024 SHALL let ae_thresh change at any time; the new value takes effect on the next edge.
REQ-025 SHALL contain no combinational path from any input to any output except raddr, which depends on state only.

Reset
REQ-026 SHALL, while rrst_n=0 and without waiting for a clock edge, force rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0 and runderflow=0.
REQ-027 SHALL, when reset is asserted mid-operation, discard any pending read, and resume normal updates from the first rclk edge after rrst_n returns high.

Verification (ADDR_SIZE=4)
REQ-028 SHALL cover reset: rrst_n=0 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=00000, raddr=0, runderflow=0.
REQ-029 SHALL cover fill: rq2_wptr=gray(3)=00010, ae_thresh=2, rinc=0, one edge -> rempty=0, rlevel=3, ralmost_empty=0.
REQ-030 SHALL cover drain: three consecutive rinc cycles -> raddr 0,1,2; after the 1st read rlevel=2 and ralmost_empty=1; after the 3rd read rempty=1, rlevel=0, rptr=00010.
REQ-031 SHALL cover underflow: rinc=1 while empty -> raddr unchanged and runderflow=1 next edge; clr_err alone -> 0; rinc-on-empty together with clr_err -> runderflow stays 1.
REQ-032 SHALL cover wrap: drive both pointers to 31 then read across the wrap -> rptr goes 10000 to 00000, raddr goes 15 to 0, rlevel stays correct (e.g. wptr=gray(2), rbin=31 gives rlevel=3).
REQ-033 SHALL cover reset mid-operation: with rlevel=5 and rinc=1, pulse rrst_n low between edges -> outputs take reset values immediately, and there is no pointer advance on the next edge.
